// File: rtl/rv_decode_pkg.sv
// Shared definitions for the RV32I/RV64I decode stage: op codes, major
// opcodes, immediate formats and the decoded-entry record held in the queue.
package rv_decode_pkg;

    localparam int OP_W = 6;

    // Compact op codes
    localparam logic [OP_W-1:0] OP_ADD     = 6'd0;
    localparam logic [OP_W-1:0] OP_SUB     = 6'd1;
    localparam logic [OP_W-1:0] OP_XOR     = 6'd2;
    localparam logic [OP_W-1:0] OP_OR      = 6'd3;
    localparam logic [OP_W-1:0] OP_AND     = 6'd4;
    localparam logic [OP_W-1:0] OP_SLL     = 6'd5;
    localparam logic [OP_W-1:0] OP_SRL     = 6'd6;
    localparam logic [OP_W-1:0] OP_SRA     = 6'd7;
    localparam logic [OP_W-1:0] OP_SLT     = 6'd8;
    localparam logic [OP_W-1:0] OP_SLTU    = 6'd9;
    localparam logic [OP_W-1:0] OP_ADDI    = 6'd10;
    localparam logic [OP_W-1:0] OP_XORI    = 6'd11;
    localparam logic [OP_W-1:0] OP_ORI     = 6'd12;
    localparam logic [OP_W-1:0] OP_ANDI    = 6'd13;
    localparam logic [OP_W-1:0] OP_SLLI    = 6'd14;
    localparam logic [OP_W-1:0] OP_SRLI    = 6'd15;
    localparam logic [OP_W-1:0] OP_SRAI    = 6'd16;
    localparam logic [OP_W-1:0] OP_SLTI    = 6'd17;
    localparam logic [OP_W-1:0] OP_SLTIU   = 6'd18;
    localparam logic [OP_W-1:0] OP_LB      = 6'd19;
    localparam logic [OP_W-1:0] OP_LH      = 6'd20;
    localparam logic [OP_W-1:0] OP_LW      = 6'd21;
    localparam logic [OP_W-1:0] OP_LBU     = 6'd22;
    localparam logic [OP_W-1:0] OP_LHU     = 6'd23;
    localparam logic [OP_W-1:0] OP_SB      = 6'd24;
    localparam logic [OP_W-1:0] OP_SH      = 6'd25;
    localparam logic [OP_W-1:0] OP_SW      = 6'd26;
    localparam logic [OP_W-1:0] OP_BEQ     = 6'd27;
    localparam logic [OP_W-1:0] OP_BNE     = 6'd28;
    localparam logic [OP_W-1:0] OP_BLT     = 6'd29;
    localparam logic [OP_W-1:0] OP_BGE     = 6'd30;
    localparam logic [OP_W-1:0] OP_BLTU    = 6'd31;
    localparam logic [OP_W-1:0] OP_BGEU    = 6'd32;
    localparam logic [OP_W-1:0] OP_JAL     = 6'd33;
    localparam logic [OP_W-1:0] OP_LUI     = 6'd34;
    localparam logic [OP_W-1:0] OP_AUIPC   = 6'd35;
    localparam logic [OP_W-1:0] OP_JALR    = 6'd36;
    localparam logic [OP_W-1:0] OP_MUL     = 6'd40;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 6'd63;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Immediate formats; FMT_R yields a zero immediate
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } imm_fmt_e;

    // Width-independent part of a decoded entry (imm/pc stored alongside)
    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            rs1_en;
        logic            rs2_en;
        logic            rd_we;
        logic            illegal;
    } dec_entry_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: selects an instruction format and produces the
// sign-extended XLEN immediate. Purely combinational.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    // Assemble the 32-bit sign-extended immediate for the selected format
    always_comb begin
        imm32 = '0;
        unique case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Widening a signed value sign-extends it to XLEN
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: combinational decode of the accepted word,
// registered into a DEPTH-entry in-order queue toward execute.
// Optional M extension decode is enabled by defining RV_M_EXT_EN.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_rs1_en,
    output logic            out_rs2_en,
    output logic            out_rd_we,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam int AW = $clog2(DEPTH);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            legal;
    logic [OP_W-1:0] op_sel;
    imm_fmt_e        fmt_sel;
    logic            en_rs1, en_rs2, en_rd;
    dec_entry_t      dec_next;
    logic [XLEN-1:0] imm_next;

    dec_entry_t      slot_reg [DEPTH];
    logic [XLEN-1:0] imm_reg  [DEPTH];
    logic [XLEN-1:0] pc_reg   [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            push, pop;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Classify the word: op code, immediate format, enables and legality
    always_comb begin
        legal   = 1'b0;
        op_sel  = OP_ILLEGAL;
        fmt_sel = FMT_R;
        en_rs1  = 1'b0;
        en_rs2  = 1'b0;
        en_rd   = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                {en_rs1, en_rs2, en_rd} = 3'b111;
                unique case (funct7)
                    7'h00: begin
                        legal = 1'b1;
                        unique case (funct3)
                            3'b000:  op_sel = OP_ADD;
                            3'b001:  op_sel = OP_SLL;
                            3'b010:  op_sel = OP_SLT;
                            3'b011:  op_sel = OP_SLTU;
                            3'b100:  op_sel = OP_XOR;
                            3'b101:  op_sel = OP_SRL;
                            3'b110:  op_sel = OP_OR;
                            default: op_sel = OP_AND;
                        endcase
                    end
                    7'h20: begin
                        if (funct3 == 3'b000) begin
                            legal  = 1'b1;
                            op_sel = OP_SUB;
                        end else if (funct3 == 3'b101) begin
                            legal  = 1'b1;
                            op_sel = OP_SRA;
                        end
                    end
`ifdef RV_M_EXT_EN
                    7'h01: begin
                        // mul..remu occupy 40..47, indexed by funct3
                        legal  = 1'b1;
                        op_sel = OP_MUL | {3'b000, funct3};
                    end
`endif
                    default: legal = 1'b0;
                endcase
            end
            OPC_OPIMM: begin
                fmt_sel = FMT_I;
                {en_rs1, en_rd} = 2'b11;
                legal = 1'b1;
                unique case (funct3)
                    3'b000: op_sel = OP_ADDI;
                    3'b010: op_sel = OP_SLTI;
                    3'b011: op_sel = OP_SLTIU;
                    3'b100: op_sel = OP_XORI;
                    3'b110: op_sel = OP_ORI;
                    3'b111: op_sel = OP_ANDI;
                    3'b001: begin
                        op_sel = OP_SLLI;
                        // RV64 shamt uses bit 25, so only [31:26] are checked
                        legal  = (XLEN == 64) ? (in_instr[31:26] == 6'h00) : (funct7 == 7'h00);
                    end
                    default: begin
                        if ((XLEN == 64) ? (in_instr[31:26] == 6'h10) : (funct7 == 7'h20)) begin
                            op_sel = OP_SRAI;
                        end else begin
                            op_sel = OP_SRLI;
                            legal  = (XLEN == 64) ? (in_instr[31:26] == 6'h00) : (funct7 == 7'h00);
                        end
                    end
                endcase
            end
            OPC_LOAD: begin
                fmt_sel = FMT_I;
                {en_rs1, en_rd} = 2'b11;
                legal = 1'b1;
                unique case (funct3)
                    3'b000:  op_sel = OP_LB;
                    3'b001:  op_sel = OP_LH;
                    3'b010:  op_sel = OP_LW;
                    3'b100:  op_sel = OP_LBU;
                    3'b101:  op_sel = OP_LHU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_STORE: begin
                fmt_sel = FMT_S;
                {en_rs1, en_rs2} = 2'b11;
                legal = 1'b1;
                unique case (funct3)
                    3'b000:  op_sel = OP_SB;
                    3'b001:  op_sel = OP_SH;
                    3'b010:  op_sel = OP_SW;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                fmt_sel = FMT_B;
                {en_rs1, en_rs2} = 2'b11;
                legal = 1'b1;
                unique case (funct3)
                    3'b000:  op_sel = OP_BEQ;
                    3'b001:  op_sel = OP_BNE;
                    3'b100:  op_sel = OP_BLT;
                    3'b101:  op_sel = OP_BGE;
                    3'b110:  op_sel = OP_BLTU;
                    3'b111:  op_sel = OP_BGEU;
                    default: legal  = 1'b0;
                endcase
            end
            OPC_JALR: begin
                fmt_sel = FMT_I;
                {en_rs1, en_rd} = 2'b11;
                op_sel  = OP_JALR;
                legal   = (funct3 == 3'b000);
            end
            OPC_JAL: begin
                fmt_sel = FMT_J;
                en_rd   = 1'b1;
                op_sel  = OP_JAL;
                legal   = 1'b1;
            end
            OPC_LUI: begin
                fmt_sel = FMT_U;
                en_rd   = 1'b1;
                op_sel  = OP_LUI;
                legal   = 1'b1;
            end
            OPC_AUIPC: begin
                fmt_sel = FMT_U;
                en_rd   = 1'b1;
                op_sel  = OP_AUIPC;
                legal   = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // Illegal words collapse to a clean record: no enables, zero immediate
        if (!legal || in_instr[1:0] != 2'b11) begin
            legal   = 1'b0;
            op_sel  = OP_ILLEGAL;
            fmt_sel = FMT_R;
            en_rs1  = 1'b0;
            en_rs2  = 1'b0;
            en_rd   = 1'b0;
        end
    end

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_sel),
        .imm   (imm_next)
    );

    // Pack the decoded record; x0 is never written
    always_comb begin
        dec_next.op      = op_sel;
        dec_next.rs1     = in_instr[19:15];
        dec_next.rs2     = in_instr[24:20];
        dec_next.rd      = in_instr[11:7];
        dec_next.rs1_en  = en_rs1;
        dec_next.rs2_en  = en_rs2;
        dec_next.rd_we   = en_rd && (in_instr[11:7] != 5'd0);
        dec_next.illegal = !legal;
    end

    assign in_ready  = (count_reg != (AW+1)'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Queue storage, pointers and occupancy; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_reg[i] <= '{op: OP_ILLEGAL, default: '0};
                imm_reg[i]  <= '0;
                pc_reg[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                slot_reg[wr_ptr_reg] <= dec_next;
                imm_reg[wr_ptr_reg]  <= imm_next;
                pc_reg[wr_ptr_reg]   <= in_pc;
                wr_ptr_reg           <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_op      = slot_reg[rd_ptr_reg].op;
    assign out_rs1     = slot_reg[rd_ptr_reg].rs1;
    assign out_rs2     = slot_reg[rd_ptr_reg].rs2;
    assign out_rd      = slot_reg[rd_ptr_reg].rd;
    assign out_rs1_en  = slot_reg[rd_ptr_reg].rs1_en;
    assign out_rs2_en  = slot_reg[rd_ptr_reg].rs2_en;
    assign out_rd_we   = slot_reg[rd_ptr_reg].rd_we;
    assign out_illegal = slot_reg[rd_ptr_reg].illegal;
    assign out_imm     = imm_reg[rd_ptr_reg];
    assign out_pc      = pc_reg[rd_ptr_reg];

endmodule

// File: tb/tb_rv_decode_stage.sv
// Self-checking bench for rv_decode_stage (XLEN=32, DEPTH=2) using a
// scoreboard of expected decoded entries.
module tb_rv_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_en, rs2_en, rd_we, ill, chk_idx;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic [5:0]      out_op;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic            out_rs1_en, out_rs2_en, out_rd_we, out_illegal;
    logic [XLEN-1:0] out_imm, out_pc;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   out_idx      = 0;
    exp_t exp_q[$];

    logic [31:0] vec_instr [13];
    exp_t        vec_exp   [13];

    rv_decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_rs1_en  (out_rs1_en),
        .out_rs2_en  (out_rs2_en),
        .out_rd_we   (out_rd_we),
        .out_imm     (out_imm),
        .out_pc      (out_pc),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input int op, input int rs1, input int rs2, input int rd,
                                input logic [2:0] en, input logic [31:0] imm);
        exp_t e;
        e.op = 6'(op); e.rs1 = 5'(rs1); e.rs2 = 5'(rs2); e.rd = 5'(rd);
        e.rs1_en = en[2]; e.rs2_en = en[1]; e.rd_we = en[0];
        e.ill = 1'b0; e.chk_idx = 1'b1; e.imm = imm; e.pc = '0;
        return e;
    endfunction

    function automatic exp_t mk_ill();
        exp_t e;
        e = mk(63, 0, 0, 0, 3'b000, 32'h0);
        e.ill = 1'b1; e.chk_idx = 1'b0;
        return e;
    endfunction

    // Drive one word from a negedge and hold it until accepted (bounded)
    task automatic send(input logic [31:0] instr, input exp_t e, output int waits);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = e.pc;
        waits    = 0;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (in_ready) begin
            exp_q.push_back(e);
            @(negedge clk);
        end else begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard: compare the head whenever it is consumed
    always begin
        @(negedge clk);
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexp_out", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("op#%0d", out_idx),     64'(out_op),      64'(e.op));
                check($sformatf("ill#%0d", out_idx),    64'(out_illegal), 64'(e.ill));
                check($sformatf("rs1en#%0d", out_idx),  64'(out_rs1_en),  64'(e.rs1_en));
                check($sformatf("rs2en#%0d", out_idx),  64'(out_rs2_en),  64'(e.rs2_en));
                check($sformatf("rdwe#%0d", out_idx),   64'(out_rd_we),   64'(e.rd_we));
                check($sformatf("imm#%0d", out_idx),    64'(out_imm),     64'(e.imm));
                check($sformatf("pc#%0d", out_idx),     64'(out_pc),      64'(e.pc));
                if (e.chk_idx) begin
                    check($sformatf("rs1#%0d", out_idx), 64'(out_rs1), 64'(e.rs1));
                    check($sformatf("rs2#%0d", out_idx), 64'(out_rs2), 64'(e.rs2));
                    check($sformatf("rd#%0d", out_idx),  64'(out_rd),  64'(e.rd));
                end
                $display("[TB] out #%0d pc=0x%0h op=%0d ill=%0b imm=0x%0h",
                         out_idx, out_pc, out_op, out_illegal, out_imm);
                out_idx++;
            end
        end
    end

    initial begin
        int   waits;
        int   pcn;
        exp_t e;

        vec_instr[0]  = 32'h00B50533; vec_exp[0]  = mk(0, 10, 11, 10, 3'b111, 32'h0);
        vec_instr[1]  = 32'hFFF00093; vec_exp[1]  = mk(10, 0, 31, 1, 3'b101, 32'hFFFFFFFF);
        vec_instr[2]  = 32'h00000013; vec_exp[2]  = mk(10, 0, 0, 0, 3'b100, 32'h0);
        vec_instr[3]  = 32'hFE000EE3; vec_exp[3]  = mk(27, 0, 0, 29, 3'b110, 32'hFFFFFFFC);
        vec_instr[4]  = 32'h0000A063; vec_exp[4]  = mk_ill();
        vec_instr[5]  = 32'h02B50533;
`ifdef RV_M_EXT_EN
        vec_exp[5]  = mk(40, 10, 11, 10, 3'b111, 32'h0);
`else
        vec_exp[5]  = mk_ill();
`endif
        vec_instr[6]  = 32'h40B50533; vec_exp[6]  = mk(1, 10, 11, 10, 3'b111, 32'h0);
        vec_instr[7]  = 32'h12345537; vec_exp[7]  = mk(34, 8, 3, 10, 3'b001, 32'h12345000);
        vec_instr[8]  = 32'h00B52423; vec_exp[8]  = mk(26, 10, 11, 8, 3'b110, 32'h8);
        vec_instr[9]  = 32'hFF9FF0EF; vec_exp[9]  = mk(33, 31, 25, 1, 3'b001, 32'hFFFFFFF8);
        vec_instr[10] = 32'h4032D293; vec_exp[10] = mk(16, 5, 3, 5, 3'b101, 32'h403);
        vec_instr[11] = 32'h40329293; vec_exp[11] = mk_ill();
        vec_instr[12] = 32'h00000000; vec_exp[12] = mk_ill();

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_out_valid", 64'(out_valid),   64'd0);
        check("rst_in_ready",  64'(in_ready),    64'd1);
        check("rst_op",        64'(out_op),      64'd63);
        check("rst_illegal",   64'(out_illegal), 64'd0);
        check("rst_rd_we",     64'(out_rd_we),   64'd0);
        check("rst_imm",       64'(out_imm),     64'd0);
        check("rst_pc",        64'(out_pc),      64'd0);

        // Single word into an empty queue: valid one cycle after accept
        pcn = 0;
        out_ready = 1'b1;
        e = vec_exp[0]; e.pc = 32'h1000 + 32'(pcn * 4); pcn++;
        send(vec_instr[0], e, waits);
        in_valid = 1'b0;
        check("latency", 64'(out_valid), 64'd1);
        wait_drain();

        // Back-to-back stream with out_ready high: no stall expected
        for (int i = 0; i < 13; i++) begin
            e = vec_exp[i]; e.pc = 32'h1000 + 32'(pcn * 4); pcn++;
            send(vec_instr[i], e, waits);
            check($sformatf("tput_wait#%0d", i), 64'(waits), 64'd0);
        end
        in_valid = 1'b0;
        wait_drain();

        // Backpressure: fill DEPTH, the next word must wait
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            e = vec_exp[i + 6]; e.pc = 32'h2000 + 32'(i * 4);
            send(vec_instr[i + 6], e, waits);
        end
        in_instr = vec_instr[DEPTH + 6];
        in_pc    = 32'h2000 + 32'(DEPTH * 4);
        for (int k = 0; k < 2; k++) begin
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("hold_pc", 64'(out_pc), 64'h2000);
            check("hold_op", 64'(out_op), 64'(vec_exp[6].op));
            @(negedge clk);
        end
        out_ready = 1'b1;
        e = vec_exp[DEPTH + 6]; e.pc = 32'h2000 + 32'(DEPTH * 4);
        send(vec_instr[DEPTH + 6], e, waits);
        in_valid = 1'b0;
        wait_drain();

        // Flush with two entries queued and a word offered the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = vec_exp[i]; e.pc = 32'h3000 + 32'(i * 4);
            send(vec_instr[i], e, waits);
        end
        in_instr = vec_instr[7];
        in_pc    = 32'h3008;
        flush    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        e = vec_exp[3]; e.pc = 32'h3100;
        send(vec_instr[3], e, waits);
        in_valid = 1'b0;
        wait_drain();

        // Reset mid-stream behaves like flush and clears the head slot
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e = vec_exp[i + 8]; e.pc = 32'h4000 + 32'(i * 4);
            send(vec_instr[i + 8], e, waits);
        end
        in_instr = vec_instr[10];
        in_pc    = 32'h4008;
        reset    = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst2_out_valid", 64'(out_valid), 64'd0);
        check("rst2_in_ready",  64'(in_ready),  64'd1);
        check("rst2_op",        64'(out_op),    64'd63);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        e = vec_exp[7]; e.pc = 32'h4100;
        send(vec_instr[7], e, waits);
        in_valid = 1'b0;
        wait_drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
